// File: rtl/sq_frame_accum.sv
// Sum-of-squares frame accumulator: sums COUNT squarer results (or fewer on flush)
// and hands the saturated sum, sample count and overflow flag downstream.
module sq_frame_accum #(
  parameter int COUNT = 16,
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t             state;
  state_t             state_nxt;

  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic               ovf;

  logic               accept;
  logic               close;
  logic               carry;
  logic [ACC_W:0]     sum_ext;
  logic [ACC_W-1:0]   acc_upd;
  logic [CNT_W-1:0]   cnt_upd;
  logic               ovf_upd;

  // Zero-extended add: the extra top bit is the overflow carry.
  function automatic logic [ACC_W:0] add_ext(input logic [ACC_W-1:0] a,
                                             input logic [7:0]       d);
    return {1'b0, a} + {{(ACC_W + 1 - 8){1'b0}}, d};
  endfunction

  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W:0] s);
    return s[ACC_W] ? {ACC_W{1'b1}} : s[ACC_W-1:0];
  endfunction

  // Ready and valid decode straight from the state register, never from inputs.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  always_comb begin
    accept  = in_valid && (state == ACCUM);
    sum_ext = add_ext(acc, in_data);
    carry   = sum_ext[ACC_W];
    acc_upd = accept ? sat_acc(sum_ext) : acc;
    cnt_upd = accept ? cnt + CNT_W'(1) : cnt;
    ovf_upd = ovf | (accept & carry);
    // A flush closes the frame only if it holds at least one sample after this cycle.
    close   = (state == ACCUM) &&
              ((accept && (cnt_upd == CNT_W'(COUNT))) ||
               (flush && ((cnt != '0) || accept)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM: if (close) state_nxt = HOLD;
      HOLD:  if (out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (close) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else begin
      acc <= acc_upd;
      cnt <= cnt_upd;
      ovf <= ovf_upd;
    end
  end

  // Result registers load the post-update frame state and hold through backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_sum   <= '0;
      out_count <= '0;
      out_ovf   <= 1'b0;
    end else if (close) begin
      out_sum   <= acc_upd;
      out_count <= cnt_upd;
      out_ovf   <= ovf_upd;
    end
  end

endmodule

// File: tb/tb_sq_frame_accum.sv
// Scoreboard bench for sq_frame_accum: a frame-level model predicts each result,
// a monitor compares every cycle the DUT presents one.
module tb_sq_frame_accum;
  localparam int COUNT  = 4;
  localparam int ACC_W  = 9;
  localparam int CNT_W  = 8;
  localparam int SATMAX = (1 << ACC_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [7:0]       in_data = 8'd0;
  logic             flush = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_sum;
  logic [CNT_W-1:0] out_count;
  logic             out_ovf;

  sq_frame_accum #(.COUNT(COUNT), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct { int sum; int count; int ovf; } exp_t;
  exp_t expq[$];
  int   frame[$];
  int   total = 0;
  int   bad = 0;
  bit   rand_rdy = 1'b0;
  bit   mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Frame model: plain sum of samples, clipped; overflow iff the true sum exceeds the max.
  function automatic void close_frame();
    exp_t e;
    int s = 0;
    foreach (frame[i]) s += frame[i];
    e.sum   = (s > SATMAX) ? SATMAX : s;
    e.ovf   = (s > SATMAX) ? 1 : 0;
    e.count = frame.size();
    expq.push_back(e);
    frame.delete();
  endfunction

  always @(negedge clk) begin
    if (rst_n && mon_en && out_valid) begin
      check("in_ready_in_hold", 32'(in_ready), 32'd0);
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_out: got out_valid=1 sum=%0d, expected no output", out_sum);
      end else begin
        check("out_sum", 32'(out_sum), 32'(expq[0].sum));
        check("out_count", 32'(out_count), 32'(expq[0].count));
        check("out_ovf", 32'(out_ovf), 32'(expq[0].ovf));
        if (out_ready) void'(expq.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  // All tasks start and end at posedge+1, so consecutive sends are back-to-back.
  task automatic send(input int d, input bit fl);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d[7:0];
    flush    = fl;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got in_ready=0 after %0d cycles, expected 1", waited);
    end
    @(posedge clk);
    frame.push_back(d);
    if (frame.size() == COUNT || fl) close_frame();
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic flush_only();
    flush    = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    if (frame.size() > 0) close_frame();
    #1 flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int waited = 0;
    rand_rdy = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    while (expq.size() != 0 && waited < 100) begin
      waited++;
      idle(1);
    end
    idle(1);
    check("drain_queue_empty", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_out_ovf", 32'(out_ovf), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b1;

    // basic frame, out_valid exactly one cycle
    send(1, 0); send(4, 0); send(9, 0); send(16, 0);
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_ready_low", 32'(in_ready), 32'd0);
    idle(1);
    check("basic_valid_drop", 32'(out_valid), 32'd0);
    check("basic_ready_back", 32'(in_ready), 32'd1);

    // backpressure: result held for 5 cycles
    out_ready = 1'b0;
    send(225, 0); send(196, 1);
    repeat (5) begin
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_sum_held", 32'(out_sum), 32'd421);
      idle(1);
    end
    out_ready = 1'b1;
    idle(1);
    check("bp_valid_drop", 32'(out_valid), 32'd0);
    check("bp_ready_back", 32'(in_ready), 32'd1);

    // saturation, recovery, and exact max without overflow
    send(255, 0); send(255, 0); send(255, 0); send(255, 0);
    send(1, 0); send(1, 0); send(1, 0); send(1, 0);
    send(255, 0); send(255, 0); send(1, 0); send(0, 0);
    send(255, 0); send(255, 0); send(2, 0); send(0, 0);

    // flush cases
    drain();
    send(36, 0); send(49, 0); flush_only();
    send(64, 1);
    drain();
    flush_only(); idle(3);
    check("flush_empty_no_valid", 32'(out_valid), 32'd0);

    // reset mid-frame
    send(1, 0); send(1, 0); send(1, 0);
    #2 rst_n = 1'b0;
    #1;
    frame.delete();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_ready", 32'(in_ready), 32'd1);
    check("mid_rst_sum", 32'(out_sum), 32'd0);
    check("mid_rst_count", 32'(out_count), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);
    send(1, 0); send(1, 0); send(1, 0); send(1, 0);
    drain();

    // reset while holding a result
    out_ready = 1'b0;
    send(7, 0); send(8, 1);
    idle(2);
    #2 rst_n = 1'b0;
    #1;
    expq.delete();
    check("hold_rst_valid", 32'(out_valid), 32'd0);
    check("hold_rst_ready", 32'(in_ready), 32'd1);
    check("hold_rst_ovf", 32'(out_ovf), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);
    out_ready = 1'b1;

    // randomized traffic with random backpressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      int r = int'($urandom_range(0, 9));
      int d = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
      if (r < 7) send(d, $urandom_range(0, 7) == 0);
      else if (r == 7) flush_only();
      else idle(1);
    end
    drain();
    check("final_queue_empty", 32'(expq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
